iblut_v2c_lookup_pipe: RTL and testbench
========================================

# iblut_v2c_lookup_pipe

Pipelined two-input IB-LUT variable-node lookup stage for the partial VNU. Consumes one channel/intermediate message and one C2V message per cycle. Produces the LUT-mapped V2C symbol plus the raw sign; the downstream sign-restore (symbol-to-integer) stage consumes both. Holds a runtime-loadable LUT, managed by a small load/run state machine, with valid/ready handshakes on both sides.

## Interface
- MSG_WIDTH, 4, message width in bits: sign in the MSB, magnitude in the rest.
- LUT_ADDR_W, 2*MSG_WIDTH-1, derived LUT address width; not overridable.
- LUT_DEPTH, 2**LUT_ADDR_W, derived LUT entry count (128 at default).
- sys_clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- load_start_i  in  1  pulse: request a full LUT (re)load.
- lut_wvalid_i  in  1  LUT write strobe, honoured only in LOAD.
- lut_wdata_i  in  MSG_WIDTH  LUT entry data, written to auto-incremented address.
- lut_busy_o  out  1  high in DRAIN or LOAD.
- in_valid_i  in  1  input message pair valid.
- in_ready_o  out  1  stage accepts input.
- ch_msg_i  in  MSG_WIDTH  channel or intermediate V2C message (operand A).
- c2v_msg_i  in  MSG_WIDTH  C2V message (operand B).
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  downstream accepts output.
- map_v2c_o  out  MSG_WIDTH  LUT mapping result (symbol form).
- raw_v2c_sign_o  out  1  sign of operand A, aligned with map_v2c_o.
- v2c_int_o  out  MSG_WIDTH  sign-restored integer V2C. Present only with IBLUT_V2C_SYM2INT_EN.

## Operation
- LUT address is {A[MSB]^B[MSB], A[MSG_WIDTH-2:0], B[MSG_WIDTH-2:0]}. The table stores sign-relative-to-A entries only.
- raw_v2c_sign = A[MSB].
- FSM states: IDLE, DRAIN, LOAD, RUN. Reset enters IDLE.
- IDLE: in_ready_o=0. load_start_i moves to LOAD, write counter cleared.
- RUN: lookups accepted. load_start_i moves to DRAIN.
- DRAIN: in_ready_o=0. Moves to LOAD in the cycle after both pipeline stages are empty.
- LOAD: each lut_wvalid_i writes lut[cnt] and increments cnt.
  - The write at cnt=LUT_DEPTH-1 moves to RUN and wraps cnt to 0.
  - load_start_i during LOAD restarts cnt at 0; it has priority over a same-cycle write, which is dropped.
  - lut_wvalid_i outside LOAD is ignored.
- LUT array is not reset; contents persist across rstn. After reset the block stays in IDLE until a full reload completes.
- Pipeline has 2 stages.
  - S1 registers the address and A sign.
  - S2 registers the LUT read data and the sign.
- Each stage loads when it is empty or its content is leaving.
- in_ready_o = (state==RUN) && (!s1_valid || s2 can accept).

## Timing
- Latency 2: a handshake at edge t gives out_valid_o after edge t+2. Throughput 1 per cycle.
- out_ready_i low: outputs held stable; bubbles fill, then in_ready_o drops.
- Reset values: out_valid_o=0, in_ready_o=0, lut_busy_o=0, map_v2c_o=0, raw_v2c_sign_o=0, v2c_int_o=0. Both stage valids are cleared.
- rstn asserted mid-stream or mid-load: in-flight data discarded, FSM to IDLE, partially loaded LUT is not trusted.
- A LUT write cannot coincide with an S2 read, because lookups only occur in RUN.

## Configuration
- IBLUT_V2C_SYM2INT_EN defined:
  - v2c_int_o is registered in S2 with latency 2.
  - v2c_int_o = {raw_sign ? sym[MSB] : ~sym[MSB], sym[MSG_WIDTH-2:0]}.
  - A downstream sign-restore stage becomes optional.
- Undefined: port and logic are absent. Only map_v2c_o and raw_v2c_sign_o are produced.

## Structure
- Shared package iblut_pkg holds:
  - state enum iblut_load_state_e {IDLE, DRAIN, LOAD, RUN};
  - function lut_addr_w(msg_width);
  - the address-packing function.
- Sub-module iblut_v2c_regfile: LUT_DEPTH×MSG_WIDTH storage, one sync write port, one registered read port (the S2 register). The FSM, counter and handshake stay in the top.

## Test plan
- Reset, then in_valid_i=1 with no load -> in_ready_o=0, out_valid_o stays 0, lut_busy_o=0.
- Load lut[i]=i%16 for all 128 entries -> lut_busy_o high for exactly 128 strobes, RUN after write 127.
- RUN, A=4'b1011, B=4'b0101 (addr 93) -> 2 cycles later map_v2c_o=4'hD, raw_v2c_sign_o=1, v2c_int_o=4'hD.
- Same load, A=4'b0011, B=4'b0101 (addr 29) -> map_v2c_o=4'hD, raw_v2c_sign_o=0, v2c_int_o=4'h5.
- Streaming with out_ready_i low 3 cycles -> outputs held, no loss or duplication, in-order recovery at 1 per cycle.
- load_start_i with 2 items in flight -> both items delivered, then LOAD. rstn pulse at write 50 -> IDLE, out_valid_o=0.

Source files
------------

// File: rtl/iblut_pkg.sv
// iblut_pkg: shared types and helpers for the IB-LUT V2C lookup stage.
// Holds the load/run state enum, LUT address width and address packing.
package iblut_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      LOAD  = 2'd2,
      RUN   = 2'd3
   } iblut_load_state_e;

   localparam int MSG_WIDTH_DEF = 4;

   function automatic int lut_addr_w(input int msg_width);
      return 2 * msg_width - 1;
   endfunction

   // {A.sign ^ B.sign, A.mag, B.mag}; the table holds entries
   // relative to the sign of A, so only the sign difference matters.
   function automatic logic [31:0] pack_addr(
      input logic [31:0] a,
      input logic [31:0] b,
      input int          msg_width
   );
      logic [31:0] m;
      logic        s;
      m = (32'd1 << (msg_width - 1)) - 32'd1;
      s = a[msg_width-1] ^ b[msg_width-1];
      return ({31'd0, s} << (2 * (msg_width - 1)))
           | ((a & m) << (msg_width - 1))
           | (b & m);
   endfunction

endpackage

// File: rtl/iblut_v2c_lookup_pipe_regfile.sv
// iblut_v2c_regfile: LUT storage, one sync write port, one registered
// read port. Ports: i_clk, i_rst_n, i_we/i_waddr/i_wdata, i_re/i_raddr, o_rdata.
module iblut_v2c_regfile #(
   parameter int AW = 7,
   parameter int DW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   // Storage is deliberately not reset; contents survive rstn.
   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we)
         r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_rdata <= '0;
      else if (i_re)
         r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/iblut_v2c_lookup_pipe.sv
// iblut_v2c_lookup_pipe: 2-stage IB-LUT V2C lookup with runtime LUT load.
// Ports: sys_clk, rstn, load_start_i, lut_wvalid_i, lut_wdata_i,
// lut_busy_o, in_valid_i/in_ready_o, ch_msg_i, c2v_msg_i,
// out_valid_o/out_ready_i, map_v2c_o, raw_v2c_sign_o, and v2c_int_o
// when IBLUT_V2C_SYM2INT_EN is defined.
module iblut_v2c_lookup_pipe
   import iblut_pkg::*;
#(
   parameter int MSG_WIDTH = MSG_WIDTH_DEF
) (
   input  logic                 sys_clk,
   input  logic                 rstn,
   input  logic                 load_start_i,
   input  logic                 lut_wvalid_i,
   input  logic [MSG_WIDTH-1:0] lut_wdata_i,
   output logic                 lut_busy_o,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [MSG_WIDTH-1:0] ch_msg_i,
   input  logic [MSG_WIDTH-1:0] c2v_msg_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [MSG_WIDTH-1:0] map_v2c_o,
   output logic                 raw_v2c_sign_o
`ifdef IBLUT_V2C_SYM2INT_EN
   ,
   output logic [MSG_WIDTH-1:0] v2c_int_o
`endif
);

   localparam int LUT_ADDR_W = lut_addr_w(MSG_WIDTH);
   localparam int LUT_DEPTH  = 2**LUT_ADDR_W;
   localparam logic [LUT_ADDR_W-1:0] LAST_A =
      LUT_ADDR_W'(LUT_DEPTH - 1);

   iblut_load_state_e r_state;
   iblut_load_state_e w_state_nx;

   logic [LUT_ADDR_W-1:0] r_cnt;
   logic                  w_lut_we;
   logic                  w_run;

   logic                  r_s1_valid;
   logic [LUT_ADDR_W-1:0] r_s1_addr;
   logic                  r_s1_sign;
   logic                  r_s2_valid;
   logic                  r_s2_sign;
   logic [MSG_WIDTH-1:0]  w_s2_sym;

   logic                  w_s2_ld;
   logic                  w_s1_ld;
   logic                  w_in_fire;
   logic [LUT_ADDR_W-1:0] w_addr;

   // State register
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn)
         r_state <= IDLE;
      else
         r_state <= w_state_nx;
   end

   // Next-state logic
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE:  if (load_start_i) w_state_nx = LOAD;
         RUN:   if (load_start_i) w_state_nx = DRAIN;
         DRAIN: if (!r_s1_valid && !r_s2_valid) w_state_nx = LOAD;
         LOAD:  if (w_lut_we && r_cnt == LAST_A) w_state_nx = RUN;
         default: w_state_nx = IDLE;
      endcase
   end

   // Output decode; a restart request wins over a same-cycle write
   always_comb begin
      w_run      = 1'b0;
      lut_busy_o = 1'b0;
      w_lut_we   = 1'b0;
      unique case (1'b1)
         (r_state == RUN):   w_run = 1'b1;
         (r_state == DRAIN): lut_busy_o = 1'b1;
         (r_state == LOAD): begin
            lut_busy_o = 1'b1;
            w_lut_we   = lut_wvalid_i && !load_start_i;
         end
         default: ;
      endcase
   end

   // Write counter only advances in LOAD; cleared everywhere else
   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn)
         r_cnt <= '0;
      else if (r_state != LOAD || load_start_i)
         r_cnt <= '0;
      else if (lut_wvalid_i)
         r_cnt <= r_cnt + LUT_ADDR_W'(1);
   end

   assign w_s2_ld    = !r_s2_valid || out_ready_i;
   assign w_s1_ld    = !r_s1_valid || w_s2_ld;
   assign in_ready_o = w_run && w_s1_ld;
   assign w_in_fire  = in_valid_i && in_ready_o;
   assign w_addr     = LUT_ADDR_W'(pack_addr(32'(ch_msg_i),
                                             32'(c2v_msg_i),
                                             MSG_WIDTH));

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         r_s1_valid <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_sign  <= 1'b0;
      end else if (w_s1_ld) begin
         r_s1_valid <= w_in_fire;
         r_s1_addr  <= w_addr;
         r_s1_sign  <= ch_msg_i[MSG_WIDTH-1];
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         r_s2_valid <= 1'b0;
         r_s2_sign  <= 1'b0;
      end else if (w_s2_ld) begin
         r_s2_valid <= r_s1_valid;
         r_s2_sign  <= r_s1_sign;
      end
   end

   // The regfile read register is the S2 symbol register
   iblut_v2c_regfile #(
      .AW (LUT_ADDR_W),
      .DW (MSG_WIDTH)
   ) u_lut (
      .i_clk   (sys_clk),
      .i_rst_n (rstn),
      .i_we    (w_lut_we),
      .i_waddr (r_cnt),
      .i_wdata (lut_wdata_i),
      .i_re    (w_s2_ld && r_s1_valid),
      .i_raddr (r_s1_addr),
      .o_rdata (w_s2_sym)
   );

   assign out_valid_o    = r_s2_valid;
   assign map_v2c_o      = w_s2_sym;
   assign raw_v2c_sign_o = r_s2_sign;

`ifdef IBLUT_V2C_SYM2INT_EN
   // Gated until S2 has held real data, so the reset value reads 0
   // rather than the sign-flipped image of a zero symbol.
   logic r_s2_seen;

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn)
         r_s2_seen <= 1'b0;
      else if (w_s2_ld && r_s1_valid)
         r_s2_seen <= 1'b1;
   end

   assign v2c_int_o = !r_s2_seen ? '0 :
      {r_s2_sign ? w_s2_sym[MSG_WIDTH-1] : ~w_s2_sym[MSG_WIDTH-1],
       w_s2_sym[MSG_WIDTH-2:0]};
`endif

endmodule

// File: tb/tb_iblut_v2c_lookup_pipe.sv
// tb_iblut_v2c_lookup_pipe: directed bench for the IB-LUT lookup stage.
// Optional IBLUT_V2C_SYM2INT_EN adds v2c_int_o checks.
module tb_iblut_v2c_lookup_pipe;

   localparam int W = 4;
   localparam int N = 8;

   logic         sys_clk = 1'b0;
   logic         rstn;
   logic         load_start_i;
   logic         lut_wvalid_i;
   logic [W-1:0] lut_wdata_i;
   logic         lut_busy_o;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [W-1:0] ch_msg_i;
   logic [W-1:0] c2v_msg_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [W-1:0] map_v2c_o;
   logic         raw_v2c_sign_o;
`ifdef IBLUT_V2C_SYM2INT_EN
   logic [W-1:0] v2c_int_o;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   iblut_v2c_lookup_pipe #(.MSG_WIDTH(W)) dut (
      .sys_clk        (sys_clk),
      .rstn           (rstn),
      .load_start_i   (load_start_i),
      .lut_wvalid_i   (lut_wvalid_i),
      .lut_wdata_i    (lut_wdata_i),
      .lut_busy_o     (lut_busy_o),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .ch_msg_i       (ch_msg_i),
      .c2v_msg_i      (c2v_msg_i),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .map_v2c_o      (map_v2c_o),
      .raw_v2c_sign_o (raw_v2c_sign_o)
`ifdef IBLUT_V2C_SYM2INT_EN
      ,
      .v2c_int_o      (v2c_int_o)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h",
                tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   // Reference: lut[i] = i % 16, address {sa^sb, a.mag, b.mag}
   function automatic logic [4:0] m_out(input logic [3:0] a,
                                        input logic [3:0] b);
      logic [6:0] ad;
      ad = {a[3] ^ b[3], a[2:0], b[2:0]};
      return {a[3], ad[3:0]};
   endfunction

   function automatic logic [3:0] m_int(input logic [4:0] e);
      return {e[4] ? e[3] : ~e[3], e[2:0]};
   endfunction

   function automatic logic [3:0] vec_a(input int k);
      logic [31:0] t;
      t = 32'(k * 3 + 1);
      return t[3:0];
   endfunction

   function automatic logic [3:0] vec_b(input int k);
      logic [31:0] t;
      t = 32'(k * 7 + 2);
      return t[3:0];
   endfunction

   logic [4:0] exp_q[$];
   logic [4:0] e;
   logic [4:0] hold;
   logic       hold_v;
   logic       saw_block;
   int         busy_cnt;
   int         sent;
   int         got;
   int         cyc;

   initial begin
      rstn         = 1'b0;
      load_start_i = 1'b0;
      lut_wvalid_i = 1'b0;
      lut_wdata_i  = '0;
      in_valid_i   = 1'b0;
      ch_msg_i     = '0;
      c2v_msg_i    = '0;
      out_ready_i  = 1'b1;
      step();
      step();
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_busy", 32'(lut_busy_o), 32'd0);
      chk("rst_map", 32'(map_v2c_o), 32'd0);
      chk("rst_sign", 32'(raw_v2c_sign_o), 32'd0);
`ifdef IBLUT_V2C_SYM2INT_EN
      chk("rst_int", 32'(v2c_int_o), 32'd0);
`endif
      rstn = 1'b1;
      step();

      // Input offered with no LUT loaded: must be refused
      in_valid_i = 1'b1;
      ch_msg_i   = 4'b1011;
      c2v_msg_i  = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_in_ready", 32'(in_ready_o), 32'd0);
         chk("idle_out_valid", 32'(out_valid_o), 32'd0);
         chk("idle_busy", 32'(lut_busy_o), 32'd0);
      end
      in_valid_i = 1'b0;

      // Full load lut[i] = i % 16
      load_start_i = 1'b1;
      step();
      load_start_i = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 128; i++) begin
         lut_wvalid_i = 1'b1;
         lut_wdata_i  = 4'(i % 16);
         if (lut_busy_o) busy_cnt++;
         step();
      end
      lut_wvalid_i = 1'b0;
      chk("load_busy_strobes", 32'(busy_cnt), 32'd128);
      chk("load_done_busy", 32'(lut_busy_o), 32'd0);
      chk("run_in_ready", 32'(in_ready_o), 32'd1);

      // Lookup addr 93
      ch_msg_i   = 4'b1011;
      c2v_msg_i  = 4'b0101;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      chk("lk93_lat1_valid", 32'(out_valid_o), 32'd0);
      step();
      chk("lk93_valid", 32'(out_valid_o), 32'd1);
      chk("lk93_map", 32'(map_v2c_o), 32'hD);
      chk("lk93_sign", 32'(raw_v2c_sign_o), 32'd1);
`ifdef IBLUT_V2C_SYM2INT_EN
      chk("lk93_int", 32'(v2c_int_o), 32'hD);
`endif
      step();
      chk("lk93_gone", 32'(out_valid_o), 32'd0);

      // Lookup addr 29
      ch_msg_i   = 4'b0011;
      c2v_msg_i  = 4'b0101;
      in_valid_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      step();
      chk("lk29_valid", 32'(out_valid_o), 32'd1);
      chk("lk29_map", 32'(map_v2c_o), 32'hD);
      chk("lk29_sign", 32'(raw_v2c_sign_o), 32'd0);
`ifdef IBLUT_V2C_SYM2INT_EN
      chk("lk29_int", 32'(v2c_int_o), 32'h5);
`endif
      step();

      // Streaming with a 3-cycle downstream stall
      sent      = 0;
      got       = 0;
      cyc       = 0;
      hold_v    = 1'b0;
      saw_block = 1'b0;
      while (got < N && cyc < 60) begin
         out_ready_i = !(cyc >= 3 && cyc <= 5);
         in_valid_i  = (sent < N);
         ch_msg_i    = vec_a(sent);
         c2v_msg_i   = vec_b(sent);
         #1;
         if (hold_v) begin
            chk("stall_hold", 32'({raw_v2c_sign_o, map_v2c_o}),
                32'(hold));
            hold_v = 1'b0;
         end
         if (!out_ready_i && out_valid_o) begin
            hold   = {raw_v2c_sign_o, map_v2c_o};
            hold_v = 1'b1;
            if (!in_ready_o) saw_block = 1'b1;
         end
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("stream_extra", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("stream_map", 32'(map_v2c_o), 32'(e[3:0]));
               chk("stream_sign", 32'(raw_v2c_sign_o), 32'(e[4]));
`ifdef IBLUT_V2C_SYM2INT_EN
               chk("stream_int", 32'(v2c_int_o), 32'(m_int(e)));
`endif
            end
            got++;
         end
         if (in_valid_i && in_ready_o) begin
            exp_q.push_back(m_out(vec_a(sent), vec_b(sent)));
            sent++;
         end
         step();
         cyc++;
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      chk("stream_count", 32'(got), 32'(N));
      chk("stream_blocked", 32'(saw_block), 32'd1);
      chk("stream_cycles", 32'(cyc), 32'(N + 5));

      // Reload request with two items in flight
      ch_msg_i   = 4'b1011;
      c2v_msg_i  = 4'b0101;
      in_valid_i = 1'b1;
      step();
      ch_msg_i     = 4'b0011;
      load_start_i = 1'b1;
      step();
      in_valid_i   = 1'b0;
      load_start_i = 1'b0;
      chk("drain_x_valid", 32'(out_valid_o), 32'd1);
      chk("drain_x", 32'({raw_v2c_sign_o, map_v2c_o}), 32'h1D);
      chk("drain_busy", 32'(lut_busy_o), 32'd1);
      chk("drain_in_ready", 32'(in_ready_o), 32'd0);
      step();
      chk("drain_y_valid", 32'(out_valid_o), 32'd1);
      chk("drain_y", 32'({raw_v2c_sign_o, map_v2c_o}), 32'h0D);
      step();
      chk("drain_empty", 32'(out_valid_o), 32'd0);
      step();
      chk("load_busy", 32'(lut_busy_o), 32'd1);

      // Reset in the middle of the reload
      for (int i = 0; i < 50; i++) begin
         lut_wvalid_i = 1'b1;
         lut_wdata_i  = 4'hF;
         step();
      end
      lut_wvalid_i = 1'b0;
      chk("w50_busy", 32'(lut_busy_o), 32'd1);
      rstn = 1'b0;
      #2;
      chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
      chk("mid_rst_busy", 32'(lut_busy_o), 32'd0);
      step();
      rstn = 1'b1;
      in_valid_i = 1'b1;
      step();
      step();
      chk("post_rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("post_rst_busy", 32'(lut_busy_o), 32'd0);
      step();
      chk("post_rst_valid", 32'(out_valid_o), 32'd0);
      in_valid_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
